// File: rtl/seven_seg_to_bcd.sv
// seven_seg_to_bcd: debounces a 7-bit active-high segment bus and decodes it back to a BCD digit.
// Latency: a pattern captured at edge E0 is accepted (outputs visible) after edge E0+STABLE_CYCLES-1.
// No backpressure: the input is sampled every cycle; define SEG_HEX_DECODE_EN to also accept hex glyphs A..F.
module seven_seg_to_bcd #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seven_seg_in,
  output logic [3:0]       bcd,
  output logic             bcd_valid,
  output logic             bcd_update,
  output logic             blank,
  output logic             pattern_error,
  output logic [ERR_W-1:0] error_count
);

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Stability counter runs 0..STABLE_CYCLES; 8 bits covers the full legal range.
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  // Registered state.
  state_t           state_q, state_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             bcd_update_q, bcd_update_d;
  logic             blank_q, blank_d;
  logic             pattern_error_q, pattern_error_d;
  logic [ERR_W-1:0] error_count_q, error_count_d;

  // Combinational helpers.
  logic             changed;
  logic             accept;
  logic             dec_legal;
  logic [3:0]       dec_digit;

  // Map the incoming segment pattern to a digit; anything not in the table is illegal.
  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'd0;
    case (seven_seg_in)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h67: dec_digit = 4'd9;
`ifdef SEG_HEX_DECODE_EN
      7'h77: dec_digit = 4'd10;
      7'h7C: dec_digit = 4'd11;
      7'h39: dec_digit = 4'd12;
      7'h5E: dec_digit = 4'd13;
      7'h79: dec_digit = 4'd14;
      7'h71: dec_digit = 4'd15;
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state logic: sample, stability count, SEEK/LOCKED control and acceptance.
  always_comb begin
    seg_d           = seven_seg_in;
    changed         = (seven_seg_in != seg_q);
    state_d         = state_q;
    bcd_d           = bcd_q;
    bcd_valid_d     = bcd_valid_q;
    blank_d         = blank_q;
    bcd_update_d    = 1'b0;
    pattern_error_d = 1'b0;
    error_count_d   = error_count_q;

    if (changed) begin
      stab_cnt_d = 8'd1;
    end else if (stab_cnt_q >= STABLE_MAX) begin
      stab_cnt_d = STABLE_MAX;
    end else begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end

    // A change while locked ends the run. With STABLE_CYCLES=1 the new pattern is
    // already stable on its capture edge, so it is accepted right here as well.
    accept = (stab_cnt_d == STABLE_MAX) && ((state_q == SEEK) || changed);

    if ((state_q == LOCKED) && changed) begin
      state_d     = SEEK;
      bcd_valid_d = 1'b0;
      blank_d     = 1'b0;
    end

    if (accept) begin
      state_d = LOCKED;
      if (seven_seg_in == 7'h00) begin
        blank_d     = 1'b1;
        bcd_valid_d = 1'b0;
      end else if (dec_legal) begin
        bcd_d        = dec_digit;
        bcd_valid_d  = 1'b1;
        blank_d      = 1'b0;
        bcd_update_d = 1'b1;
      end else begin
        bcd_valid_d     = 1'b0;
        blank_d         = 1'b0;
        pattern_error_d = 1'b1;
        if (error_count_q != {ERR_W{1'b1}}) begin
          error_count_d = error_count_q + 1'b1;
        end
      end
    end
  end

  // State and output registers; reset dominates and discards any partial debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= SEEK;
      seg_q           <= 7'h00;
      stab_cnt_q      <= 8'd0;
      bcd_q           <= 4'd0;
      bcd_valid_q     <= 1'b0;
      bcd_update_q    <= 1'b0;
      blank_q         <= 1'b0;
      pattern_error_q <= 1'b0;
      error_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      seg_q           <= seg_d;
      stab_cnt_q      <= stab_cnt_d;
      bcd_q           <= bcd_d;
      bcd_valid_q     <= bcd_valid_d;
      bcd_update_q    <= bcd_update_d;
      blank_q         <= blank_d;
      pattern_error_q <= pattern_error_d;
      error_count_q   <= error_count_d;
    end
  end

  assign bcd           = bcd_q;
  assign bcd_valid     = bcd_valid_q;
  assign bcd_update    = bcd_update_q;
  assign blank         = blank_q;
  assign pattern_error = pattern_error_q;
  assign error_count   = error_count_q;

endmodule

// File: tb/tb_seven_seg_to_bcd.sv
// Testbench for seven_seg_to_bcd: random and directed segment runs, scoreboard of acceptance events.
// Main instance uses STABLE_CYCLES=4/ERR_W=8; a second instance uses STABLE_CYCLES=1/ERR_W=2.
// Stimulus pushes expected events; a negedge monitor pops them whenever the DUT reports one.
module tb_seven_seg_to_bcd;
  localparam int S = 4;
  localparam int K_UPD   = 0;
  localparam int K_BLANK = 1;
  localparam int K_ERR   = 2;
`ifdef SEG_HEX_DECODE_EN
  localparam int N_LEGAL = 16;
`else
  localparam int N_LEGAL = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset  = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic [6:0] seg2   = 7'h00;

  logic [3:0] bcd;
  logic       bcd_valid, bcd_update, blank, pattern_error;
  logic [7:0] error_count;

  logic [3:0] bcd2;
  logic       bcd_valid2, bcd_update2, blank2, perr2;
  logic [1:0] ec2;

  seven_seg_to_bcd #(.STABLE_CYCLES(S), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .seven_seg_in(seg_in),
    .bcd(bcd), .bcd_valid(bcd_valid), .bcd_update(bcd_update), .blank(blank),
    .pattern_error(pattern_error), .error_count(error_count)
  );

  seven_seg_to_bcd #(.STABLE_CYCLES(1), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .seven_seg_in(seg2),
    .bcd(bcd2), .bcd_valid(bcd_valid2), .bcd_update(bcd_update2), .blank(blank2),
    .pattern_error(perr2), .error_count(ec2)
  );

  typedef struct {
    int kind;
    int digit;
    int errc;
    int cyc;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc     = 0;
  int         total   = 0;
  int         bad     = 0;
  int         errc_m  = 0;
  int         n_perr2 = 0;
  logic [6:0] prev    = 7'h00;
  bit         fresh   = 1'b1;
  logic       blank_prev = 1'b0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference classification straight from the glyph table.
  task automatic classify(input logic [6:0] p, output int kind, output int digit);
    kind  = K_ERR;
    digit = 0;
    if (p == 7'h00) kind = K_BLANK;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (glyph[i] == p) begin
        kind  = K_UPD;
        digit = i;
      end
    end
  endtask

  // Hold pattern p for L edges; a run of at least S edges is accepted once, S-1 edges after capture.
  task automatic run(input logic [6:0] p, input int L);
    ev_t e;
    int  k, d;
    seg_in = p;
    if (L >= S && (fresh || p != prev)) begin
      classify(p, k, d);
      if (k == K_ERR && errc_m < 255) errc_m++;
      e.kind  = k;
      e.digit = d;
      e.errc  = errc_m;
      e.cyc   = cyc + S;
      exp_q.push_back(e);
    end
    prev  = p;
    fresh = 1'b0;
    repeat (L) @(negedge clk);
  endtask

  // Monitor: any pulse or a rising blank is one acceptance event.
  always @(negedge clk) begin
    ev_t e;
    int  k;
    if (!reset && (bcd_update || pattern_error || (blank && !blank_prev))) begin
      k = bcd_update ? K_UPD : (pattern_error ? K_ERR : K_BLANK);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got kind %0d at cyc %0d, expected no event", k, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", k, e.kind);
        check("ev_cyc", cyc, e.cyc);
        check("ev_dual_pulse", int'(bcd_update & pattern_error), 0);
        check("ev_bcd_valid", int'(bcd_valid), int'(e.kind == K_UPD));
        check("ev_blank", int'(blank), int'(e.kind == K_BLANK));
        check("ev_error_count", int'(error_count), e.errc);
        if (e.kind == K_UPD) check("ev_bcd", int'(bcd), e.digit);
      end
    end
    blank_prev = blank;
  end

  always @(negedge clk) if (perr2) n_perr2++;

  initial begin
    logic [6:0] p;
    logic [6:0] ill [5] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10};

    // Reset state.
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_bcd", int'(bcd), 0);
    check("rst_bcd_valid", int'(bcd_valid), 0);
    check("rst_bcd_update", int'(bcd_update), 0);
    check("rst_blank", int'(blank), 0);
    check("rst_pattern_error", int'(pattern_error), 0);
    check("rst_error_count", int'(error_count), 0);

    // Release with a blank bus, then walk the decimal digits.
    reset = 1'b0;
    fresh = 1'b1;
    errc_m = 0;
    run(7'h00, 8);
    for (int d = 0; d < 10; d++) run(glyph[d], 8);

    // Short glitch of a legal pattern inside a stable 2.
    run(7'h5B, 8);
    seg_in = 7'h7F;
    prev   = 7'h7F;
    @(negedge clk);
    check("glitch_valid_low", int'(bcd_valid), 0);
    @(negedge clk);
    check("glitch_no_update", int'(bcd_update), 0);
    run(7'h5B, 8);

    // Hex glyph A.
    run(7'h77, 8);
    check("hex_a_valid", int'(bcd_valid), int'(N_LEGAL == 16));

    // Random runs, some shorter than the debounce window.
    repeat (80) begin
      do begin
        case ($urandom_range(0, 3))
          0:       p = glyph[$urandom_range(0, 15)];
          1:       p = 7'h00;
          default: p = 7'($urandom_range(0, 127));
        endcase
      end while (p == prev);
      run(p, $urandom_range(1, 8));
    end

    // Reset two cycles into debouncing 1.
    run(7'h00, 8);
    run(7'h06, 2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_update", int'(bcd_update), 0);
    @(negedge clk);
    check("midrst_bcd", int'(bcd), 0);
    check("midrst_valid", int'(bcd_valid), 0);
    check("midrst_blank", int'(blank), 0);
    check("midrst_error_count", int'(error_count), 0);
    reset  = 1'b0;
    fresh  = 1'b1;
    errc_m = 0;
    run(7'h06, 8);

    // Narrow error counter, single-cycle debounce.
    check("ec2_start", int'(ec2), 0);
    for (int i = 0; i < 5; i++) begin
      seg2 = ill[i];
      @(negedge clk);
      check("perr2_on_capture", int'(perr2), 1);
      @(negedge clk);
      check("perr2_single", int'(perr2), 0);
    end
    check("perr2_count", n_perr2, 5);
    check("ec2_saturated", int'(ec2), 3);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
